// File: rtl/bus_memory_responder.sv
// ---------------------------------------------------------------------------
// bus_memory_responder
//   Memory-side responder for the top8227 CPU bus. It decodes the 16-bit CPU
//   address into a RAM at 0x0000 (2**RAM_AW bytes) and six programmable vector
//   bytes at 0xFFFA..0xFFFF. Everything else is unmapped. Read data is
//   registered. Optional wait states throttle the CPU through ready.
//
//   With WAIT_STATES = 0 the bus is sampled on every posedge, and the access
//   completes on that same edge. With WAIT_STATES > 0 the request is latched
//   in IDLE and performed when the WAIT counter reaches zero. ready is then
//   high for the DONE cycle and for the following IDLE cycle. While WAIT and
//   DONE are active, the bus inputs are ignored.
//
//   Optional feature macro: MEM_WRITE_PROTECT_EN. When it is defined, RAM
//   writes that fall inside [PROT_LO, PROT_HI] are dropped, and wp_violation
//   pulses for one cycle. When it is not defined, wp_violation stays 0.
//
// Ports
//   clk             in   system clock (posedge)
//   nrst            in   synchronous active-low reset
//   AddressBusHigh  in   CPU address [15:8]
//   AddressBusLow   in   CPU address [7:0]
//   readNotWrite    in   1 = read, 0 = write
//   dataBusOutput   in   CPU write data
//   dataBusInput    out  registered read data to CPU
//   ready           out  1 = access completes, 0 = CPU stalls
//   cfg_we          in   vector byte write strobe
//   cfg_sel         in   vector byte select 0..5 (0xFFFA..0xFFFF), 6/7 ignored
//   cfg_data        in   vector byte value
//   bus_error       out  one-cycle pulse on an unmapped access
//   wp_violation    out  one-cycle pulse on a write blocked by the window
// ---------------------------------------------------------------------------
module bus_memory_responder #(
  parameter int unsigned RAM_AW       = 11,
  parameter int unsigned WAIT_STATES  = 0,
  parameter logic [15:0] NMI_VECTOR   = 16'h0000,
  parameter logic [15:0] RESET_VECTOR = 16'hCCDB,
  parameter logic [15:0] IRQ_VECTOR   = 16'hCCCA,
  parameter logic [15:0] PROT_LO      = 16'h0000,
  parameter logic [15:0] PROT_HI      = 16'h00FF
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] AddressBusHigh,
  input  logic [7:0] AddressBusLow,
  input  logic       readNotWrite,
  input  logic [7:0] dataBusOutput,
  output logic [7:0] dataBusInput,
  output logic       ready,
  input  logic       cfg_we,
  input  logic [2:0] cfg_sel,
  input  logic [7:0] cfg_data,
  output logic       bus_error,
  output logic       wp_violation
);

  localparam int unsigned RAM_DEPTH = 32'd1 << RAM_AW;
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);
  localparam bit          NO_WAIT   = (WAIT_STATES == 32'd0);
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit          PROT_EN   = 1'b1;
`else
  localparam bit          PROT_EN   = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     req_addr_q, req_addr_d;
  logic            req_rnw_q, req_rnw_d;
  logic [7:0]      req_wdata_q, req_wdata_d;
  logic [7:0]      dout_q, dout_d;
  logic            ready_q, ready_d;
  logic            berr_q, berr_d;
  logic            wp_q, wp_d;
  logic [5:0][7:0] vec_q, vec_d;
  logic [7:0]      ram_q [RAM_DEPTH];

  logic [15:0]     bus_addr_s;
  logic [15:0]     acc_addr_s;
  logic            acc_rnw_s;
  logic [7:0]      acc_wdata_s;
  logic            acc_go_s;
  logic            is_ram_s;
  logic            is_vec_s;
  logic            in_window_s;
  logic            wp_hit_s;
  logic            ram_we_s;
  logic [2:0]      vec_idx_s;
  logic [7:0]      rdata_s;

  // Select the access source: the live bus when there are no wait states, otherwise the latched request.
  always_comb begin
    bus_addr_s = {AddressBusHigh, AddressBusLow};
    if (NO_WAIT) begin
      acc_addr_s  = bus_addr_s;
      acc_rnw_s   = readNotWrite;
      acc_wdata_s = dataBusOutput;
      acc_go_s    = (state_q == S_IDLE);
    end else begin
      acc_addr_s  = req_addr_q;
      acc_rnw_s   = req_rnw_q;
      acc_wdata_s = req_wdata_q;
      acc_go_s    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    end
  end

  // Decode the address, form the read data and the RAM write enable.
  always_comb begin
    is_ram_s    = ({1'b0, acc_addr_s} < RAM_LIMIT);
    is_vec_s    = (acc_addr_s >= 16'hFFFA);
    // 0xFFFA has low bits 3'b010, so subtracting 2 gives byte index 0..5.
    vec_idx_s   = acc_addr_s[2:0] - 3'd2;
    // A single unsigned compare covers both window bounds (PROT_HI >= PROT_LO).
    in_window_s = ((acc_addr_s - PROT_LO) <= (PROT_HI - PROT_LO));
    wp_hit_s    = PROT_EN && in_window_s && is_ram_s;
    if (is_ram_s) begin
      rdata_s = ram_q[acc_addr_s[RAM_AW-1:0]];
    end else if (is_vec_s) begin
      rdata_s = vec_q[vec_idx_s];
    end else begin
      rdata_s = 8'hFF;
    end
    // If reset is asserted on the commit edge, the pending write is dropped.
    ram_we_s = nrst && acc_go_s && !acc_rnw_s && is_ram_s && !wp_hit_s;
  end

  // Next-state logic: FSM sequencing, access results and vector updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    req_rnw_d   = req_rnw_q;
    req_wdata_d = req_wdata_q;
    dout_d      = dout_q;
    ready_d     = ready_q;
    berr_d      = 1'b0;
    wp_d        = 1'b0;
    vec_d       = vec_q;

    // The cfg port may write at any time. A CPU read on the same edge has already used vec_q.
    if (cfg_we && (cfg_sel <= 3'd5)) begin
      vec_d[cfg_sel] = cfg_data;
    end else begin
      vec_d = vec_q;
    end

    case (state_q)
      S_IDLE: begin
        if (NO_WAIT) begin
          ready_d = 1'b1;
        end else begin
          req_addr_d  = bus_addr_s;
          req_rnw_d   = readNotWrite;
          req_wdata_d = dataBusOutput;
          cnt_d       = 4'(WAIT_STATES - 32'd1);
          ready_d     = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (acc_go_s) begin
      if (acc_rnw_s) begin
        dout_d = rdata_s;
      end else begin
        dout_d = dout_q;
      end
      berr_d = !is_ram_s && !is_vec_s;
      wp_d   = !acc_rnw_s && wp_hit_s;
    end else begin
      berr_d = 1'b0;
      wp_d   = 1'b0;
    end
  end

  // State and output registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_addr_q  <= 16'h0000;
      req_rnw_q   <= 1'b1;
      req_wdata_q <= 8'h00;
      dout_q      <= 8'h00;
      ready_q     <= 1'b0;
      berr_q      <= 1'b0;
      wp_q        <= 1'b0;
      vec_q       <= {IRQ_VECTOR, RESET_VECTOR, NMI_VECTOR};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      req_rnw_q   <= req_rnw_d;
      req_wdata_q <= req_wdata_d;
      dout_q      <= dout_d;
      ready_q     <= ready_d;
      berr_q      <= berr_d;
      wp_q        <= wp_d;
      vec_q       <= vec_d;
    end
  end

  // RAM array. Reset does not clear its contents.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[acc_addr_s[RAM_AW-1:0]] <= acc_wdata_s;
    end
  end

  assign dataBusInput = dout_q;
  assign ready        = ready_q;
  assign bus_error    = berr_q;
  assign wp_violation = wp_q;

endmodule
